// File: rtl/ripple_sampler_pkg.sv
// Shared types and sizing helpers for the ripple count sampler.
package ripple_sampler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        COUNT,
        SETTLE,
        CAPTURE,
        HOLD
    } state_t;

    // CAPTURE may accept a match only once vld_pipe[CAP_STAGES] is set, i.e. after
    // both synchroniser stages and the compare register hold post-entry samples.
    localparam int CAP_STAGES = 1;

    // The phase counter counts SETTLE_CYCLES-1 down to 0.
    function automatic int phase_width(input int settle_cycles);
        return (settle_cycles < 2) ? 1 : $clog2(settle_cycles);
    endfunction

endpackage

// File: rtl/ripple_count_sampler_if.sv
// Request / result handshake between a consumer and the ripple count sampler.
interface ripple_count_sampler_if #(
    parameter int LENGTH       = 14,
    parameter int WINDOW_WIDTH = 16
);
    logic                    start;
    logic [WINDOW_WIDTH-1:0] window_len;
    logic                    busy;
    logic [LENGTH-1:0]       result;
    logic                    overflow;
    logic                    result_valid;
    logic                    result_ready;

    modport master (
        output start, window_len, result_ready,
        input  busy, result, overflow, result_valid
    );

    modport slave (
        input  start, window_len, result_ready,
        output busy, result, overflow, result_valid
    );
endinterface

// File: rtl/sync_2ff.sv
// Plain two-flop synchroniser; no reset so the data path stays a clean flop chain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        meta <= d;
        q    <= meta;
    end
endmodule

// File: rtl/ripple_count_sampler.sv
// Opens a counting window on the ripple incrementer, waits for the chain to settle
// and captures a stable count with a sticky wrap flag onto a valid/ready output.
module ripple_count_sampler
    import ripple_sampler_pkg::*;
#(
    parameter int LENGTH        = 14,
    parameter int WINDOW_WIDTH  = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    ripple_count_sampler_if.slave bus,
    output logic                  cnt_enable,
    output logic                  cnt_reset,
    input  logic [LENGTH-1:0]     cnt_in
);
    localparam int            PW         = phase_width(SETTLE_CYCLES);
    localparam logic [PW-1:0] PHASE_LOAD = PW'(SETTLE_CYCLES - 1);

    state_t                  state;
    logic [PW-1:0]           phase;
    logic [WINDOW_WIDTH-1:0] win_cnt;
    logic [LENGTH-1:0]       samp;
    logic [LENGTH-1:0]       samp_prev;
    logic [LENGTH-1:0]       result_q;
    logic [CAP_STAGES:0]     vld_pipe;
    logic                    wrap_seen;
    logic                    ovf_q;
    logic                    valid_q;
    logic                    msb_fall;
    logic                    samples_match;

    sync_2ff #(.WIDTH(LENGTH)) u_sync (
        .clk (clk),
        .d   (cnt_in),
        .q   (samp)
    );

    always_ff @(posedge clk) samp_prev <= samp;

    assign msb_fall      = samp_prev[LENGTH-1] & ~samp[LENGTH-1];
    assign samples_match = (samp == samp_prev);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= '0;
            win_cnt   <= '0;
            vld_pipe  <= '0;
            wrap_seen <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            vld_pipe <= '0;
            if ((state == COUNT || state == SETTLE) && msb_fall)
                wrap_seen <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state     <= CLEAR;
                        phase     <= PHASE_LOAD;
                        win_cnt   <= bus.window_len;
                        wrap_seen <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (phase == '0) begin
                        phase <= PHASE_LOAD;
                        state <= (win_cnt == '0) ? SETTLE : COUNT;
                    end else begin
                        phase <= phase - PW'(1);
                    end
                end
                COUNT: begin
                    win_cnt <= win_cnt - WINDOW_WIDTH'(1);
                    if (win_cnt == WINDOW_WIDTH'(1)) begin
                        state <= SETTLE;
                        phase <= PHASE_LOAD;
                    end
                end
                SETTLE: begin
                    if (phase == '0) state <= CAPTURE;
                    else             phase <= phase - PW'(1);
                end
                CAPTURE: begin
                    // Only samples taken after entry count; stale pre-settle values are ignored.
                    vld_pipe <= {vld_pipe[CAP_STAGES-1:0], 1'b1};
                    if (vld_pipe[CAP_STAGES] && samples_match) begin
                        result_q <= samp;
                        ovf_q    <= wrap_seen;
                        valid_q  <= 1'b1;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.result_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset gates enable combinationally so the two controls never overlap.
    assign cnt_enable       = (state == COUNT) & ~reset;
    assign cnt_reset        = reset | (state == CLEAR);
    assign bus.busy         = (state != IDLE);
    assign bus.result       = result_q;
    assign bus.overflow     = ovf_q;
    assign bus.result_valid = valid_q;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Randomised bench: behavioural ripple incrementer plus window/latency/count reference.
module tb_ripple_count_sampler;
    localparam int LENGTH       = 14;
    localparam int WINDOW_WIDTH = 16;
    localparam int S            = 4;
    localparam int CLK_HALF     = 50;

    logic              clk     = 1'b0;
    logic              reset   = 1'b1;
    logic              inc_clk = 1'b0;
    logic              cnt_enable;
    logic              cnt_reset;
    logic [LENGTH-1:0] cnt_in;
    int                ev       = 0;
    int                inc_half = 150;
    int                errors   = 0;
    int                checks   = 0;
    int                overlap  = 0;
    int                seen;

    ripple_count_sampler_if #(.LENGTH(LENGTH), .WINDOW_WIDTH(WINDOW_WIDTH)) bus ();

    ripple_count_sampler #(
        .LENGTH        (LENGTH),
        .WINDOW_WIDTH  (WINDOW_WIDTH),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .cnt_enable (cnt_enable),
        .cnt_reset  (cnt_reset),
        .cnt_in     (cnt_in)
    );

    always #(CLK_HALF) clk = ~clk;

    initial begin
        #23;
        forever #(inc_half) inc_clk = ~inc_clk;
    end

    // Asynchronous ripple incrementer: ev is the exact number of counted events.
    always @(posedge inc_clk or posedge cnt_reset) begin
        if (cnt_reset)       ev <= 0;
        else if (cnt_enable) ev <= ev + 1;
    end
    assign cnt_in = ev[LENGTH-1:0];

    always @(negedge clk) if (cnt_enable && cnt_reset) overlap <= overlap + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Entered at #1 after an edge with the DUT idle.
    task automatic run(input int n, input int rdy_wait, input bit poke);
        int k, en, limit, per;
        logic [LENGTH-1:0] exp_res;
        logic exp_ovf;
        bus.window_len = WINDOW_WIDTH'(n);
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_t1", bus.busy, 1);
        chk("clr_t1", cnt_reset, 1);
        k = 1; en = 0; limit = 2*S + n + 100;
        while (!bus.result_valid && k < limit) begin
            if (cnt_enable) en++;
            bus.start = poke && (k == 2 || k == S + 5);
            if (bus.start) bus.window_len = WINDOW_WIDTH'(n + 37);
            @(posedge clk); #1;
            k++;
        end
        bus.start = 1'b0;
        if (!bus.result_valid) begin
            chk("timeout", 0, 1);
            return;
        end
        per     = 2 * inc_half;
        exp_res = LENGTH'(ev % (1 << LENGTH));
        exp_ovf = (ev >= (1 << LENGTH));
        chk("latency", k, 2*S + n + 4);
        chk("en_cycles", en, n);
        chk("result", bus.result, exp_res);
        chk("overflow", bus.overflow, exp_ovf);
        chk("events_range", (ev*per <= n*2*CLK_HALF + per) && (ev*per + per >= n*2*CLK_HALF), 1);
        for (int i = 0; i < rdy_wait; i++) begin
            bus.start = poke && (i == rdy_wait / 2);
            @(posedge clk); #1;
            bus.start = 1'b0;
            chk("hold_valid", bus.result_valid, 1);
            chk("hold_result", {bus.overflow, bus.result}, {exp_ovf, exp_res});
        end
        bus.start        = poke;
        bus.result_ready = 1'b1;
        @(posedge clk); #1;
        bus.start        = 1'b0;
        bus.result_ready = 1'b0;
        chk("idle_after_hs", bus.busy, 0);
        chk("valid_drop", bus.result_valid, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("no_queued_start", bus.busy, 0);
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.window_len   = '0;
        bus.result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_en", cnt_enable, 0);
        chk("rst_cnt_reset", cnt_reset, 1);
        chk("rst_result", bus.result, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_valid", bus.result_valid, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_cnt_reset", cnt_reset, 0);

        inc_half = 150; run(300, 0, 0);
        run(0, 2, 0);
        inc_half = 100; run(34000, 0, 0);
        inc_half = 150; run(60, 50, 1);
        run(120, 3, 1);

        // Abort 20 cycles into COUNT.
        bus.window_len = WINDOW_WIDTH'(200);
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (S + 20) @(posedge clk);
        #1;
        chk("mid_count_en", cnt_enable, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_en", cnt_enable, 0);
        chk("abort_cnt_reset", cnt_reset, 1);
        chk("abort_busy", bus.busy, 0);
        chk("abort_valid", bus.result_valid, 0);
        reset = 1'b0;
        seen  = 0;
        repeat (2*S + 220) begin
            @(posedge clk); #1;
            if (bus.result_valid || bus.busy) seen++;
        end
        chk("no_result_after_abort", seen, 0);
        run(300, 0, 0);

        for (int i = 0; i < 6; i++) begin
            inc_half = $urandom_range(60, 400);
            run($urandom_range(0, 500), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
        end

        chk("ctrl_exclusive", overlap, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ripple_count_sampler.md
# ripple_count_sampler

Control and capture stage that sits directly downstream of the ripple incrementer. It drives the incrementer's `enable` and `reset` inputs to open a counting window of programmable length. After the window closes, it waits for the asynchronous ripple chain to settle and captures a glitch-free count into the `clk` domain. The result goes out on a valid/ready handshake, with a sticky wrap (overflow) flag.

## Interface
- `LENGTH`, 14: width of the incrementer count being sampled.
- `WINDOW_WIDTH`, 16: width of the window-length input.
- `SETTLE_CYCLES`, 4: `clk` cycles used for the clear phase and for the post-window settle phase; must be ≥ 2.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request to run a measurement; honoured only in IDLE.
- `window_len`  in  WINDOW_WIDTH  number of `clk` cycles the counter is enabled; sampled with `start`.
- `busy`  out  1  high in every state except IDLE.
- `cnt_enable`  out  1  drives the incrementer `enable`.
- `cnt_reset`  out  1  drives the incrementer `reset`.
- `cnt_in`  in  LENGTH  incrementer count; asynchronous to `clk`.
- `result`  out  LENGTH  captured count; stable while `result_valid` is high.
- `overflow`  out  1  count wrapped at least once during the window; qualified by `result_valid`.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  consumer accepts the result.

## Operation
- States:
  - IDLE: `start` → CLEAR; latch `window_len`; clear `overflow`.
  - CLEAR: `cnt_reset` = 1 for SETTLE_CYCLES, then go to COUNT. If the latched `window_len` is 0, go straight to SETTLE instead.
  - COUNT: `cnt_enable` = 1 for exactly `window_len` cycles, then go to SETTLE.
  - SETTLE: both controls 0 for SETTLE_CYCLES, then go to CAPTURE.
  - CAPTURE: compare successive synchronised samples of `cnt_in`. On the first cycle two consecutive samples are equal, load `result` and go to HOLD.
  - HOLD: `result_valid` = 1; the handshake `result_valid & result_ready` → IDLE.
- `cnt_enable` and `cnt_reset` are never high together.
- `cnt_in` passes through a 2-FF synchroniser, `LENGTH` bits wide. Multi-bit sampling is legal only because capture happens after counting has stopped; the equality check rejects any residual ripple.
- Overflow detection:
  - Applies during COUNT and SETTLE.
  - A 1→0 transition of the synchronised MSB sets sticky `overflow`.
  - Guaranteed only when the MSB period exceeds 3 `clk` cycles; faster wraps are outside specification.
- `start` in any state other than IDLE is ignored; it is not queued.
- `start` in the same cycle as a HOLD handshake is ignored. A new `start` must arrive while in IDLE.
- Window counter: WINDOW_WIDTH bits, counts down. No wrap is possible because its load value is bounded by `window_len`.

## Timing
- Reset values:
  - state IDLE.
  - `busy` = 0.
  - `cnt_enable` = 0.
  - `cnt_reset` = 1 while `reset` is high (`cnt_reset` = `reset` OR state==CLEAR), otherwise 0 in IDLE.
  - `result` = 0, `overflow` = 0, `result_valid` = 0.
- Reset asserted mid-operation aborts at the next edge:
  - counter is cleared;
  - any pending result is discarded;
  - no `result_valid` is produced.
- `start` is seen high at edge t. Then:
  - `busy` and `cnt_reset` are high from t+1.
  - `cnt_enable` is high for cycles t+1+S … t+S+N, where S = SETTLE_CYCLES and N = `window_len`.
  - Earliest `result_valid` is at t+1+2S+N+3: 2 sync stages plus 1 compare cycle.
- `result`/`overflow` change only on the entry to HOLD.
- HOLD persists indefinitely under backpressure. Returning to IDLE takes 1 cycle after the handshake.
- Minimum spacing between accepted `start` pulses: 2S+N+5 cycles.

## Structure
- Package `ripple_sampler_pkg`:
  - state enum (IDLE, CLEAR, COUNT, SETTLE, CAPTURE, HOLD);
  - width of the phase counter, derived from SETTLE_CYCLES.
- Sub-module `sync_2ff`: parameterised width, two flops, no reset on the data path.
- Top level holds the FSM, the phase and window down-counters, the capture compare, the overflow detect and the output registers.

## Test plan
- Basic measurement:
  - Stimulus: `clk` 100 MHz, incrementer clock 33.3 MHz, `window_len` = 300.
  - Required: `cnt_enable` high exactly 300 cycles; `result` ∈ {99, 100, 101}; `overflow` = 0; `result_valid` at t+312 with S=4.
- Zero window:
  - Stimulus: `window_len` = 0.
  - Required: `cnt_enable` never high; `result` = 0; `overflow` = 0; `result_valid` at t+12.
- Overflow:
  - Stimulus: LENGTH = 4, incrementer clock = `clk`/4, `window_len` = 80 (20 events).
  - Required: `result` = 4, `overflow` = 1.
- Backpressure:
  - Stimulus: hold `result_ready` = 0 for 50 cycles; pulse `start` during HOLD.
  - Required: `result`/`result_valid` stable; `start` ignored; IDLE one cycle after `result_ready` = 1.
- Reset mid-COUNT:
  - Stimulus: assert `reset` 20 cycles into COUNT.
  - Required: next cycle `cnt_enable` = 0, `cnt_reset` = 1, `busy` = 0; no `result_valid`; a following run returns a correct count.
- Start while busy:
  - Stimulus: pulse `start` in CLEAR and in COUNT.
  - Required: no restart; latched `window_len` unchanged; exactly one result produced.
